// File: rtl/palette_pkg.sv
// Shared types, reset palette contents and the brightness scaling helper
// for the palette controller and its fade engine.
package palette_pkg;

  localparam int PAL_CH_W    = 4;
  localparam int PAL_ENTRIES = 16;

  typedef logic [3*PAL_CH_W-1:0] color_t;

  // Entry 0 first; both banks come out of reset holding this table.
  localparam color_t DEFAULT_PALETTE [PAL_ENTRIES] = '{
    12'hFFF, 12'h121, 12'h999, 12'h454, 12'hDDC, 12'h111, 12'h776, 12'h343,
    12'hFFF, 12'hCCB, 12'h888, 12'h000, 12'hEEE, 12'h232, 12'hEDD, 12'hAAA
  };

  typedef enum logic {
    IDLE   = 1'b0,
    FADING = 1'b1
  } fade_state_t;

  // (c * (level + 1)) >> 4 in 8 bits: level 15 is identity, level 0 is black.
  function automatic logic [PAL_CH_W-1:0] scale_channel(
    input logic [PAL_CH_W-1:0] c,
    input logic [3:0]          level
  );
    logic [7:0] prod;
    prod = 8'(c) * (8'(level) + 8'd1);
    return prod[7:4];
  endfunction

endpackage

// File: rtl/palette_ctrl_if.sv
// Valid/ready shadow-palette write port between game logic and the controller.
interface palette_ctrl_if
  import palette_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CH_W  = 4
);
  logic                wr_valid;
  logic                wr_ready;
  logic [IDX_W-1:0]    wr_index;
  logic [3*CH_W-1:0]   wr_color;

  modport master (
    output wr_valid,
    output wr_index,
    output wr_color,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_index,
    input  wr_color,
    output wr_ready
  );
endinterface

// File: rtl/palette_fader.sv
// Frame-stepped fade engine: holds the brightness level and steps it once
// every FADE_FRAMES frame boundaries until the fade endpoint is reached.
module palette_fader
  import palette_pkg::*;
#(
  parameter int FADE_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       fade_start,
  input  logic       fade_dir,
  output logic [3:0] level,
  output logic       fade_busy
);

  localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  fade_state_t      state_reg, state_next;
  logic             dir_reg, dir_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       level_reg, level_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      dir_reg   <= 1'b0;
      cnt_reg   <= '0;
      level_reg <= 4'd15;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    case (state_reg)
      IDLE: begin
        if (fade_start) begin
          state_next = FADING;
          dir_next   = fade_dir;
          cnt_next   = '0;
        end
      end
      FADING: begin
        if (frame_start) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            // Already at the endpoint: leave without touching the level.
            if (dir_reg ? (level_reg == 4'd15) : (level_reg == 4'd0)) begin
              state_next = IDLE;
            end else begin
              level_next = dir_reg ? (level_reg + 4'd1) : (level_reg - 4'd1);
              if (dir_reg ? (level_reg == 4'd14) : (level_reg == 4'd1)) begin
                state_next = IDLE;
              end
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign level     = level_reg;
  assign fade_busy = (state_reg == FADING);

endmodule

// File: rtl/palette_ctrl.sv
// Double-buffered palette: shadow bank written via valid/ready, published to the
// active bank at a frame boundary; 2-stage lookup with fade scaling.
module palette_ctrl
  import palette_pkg::*;
#(
  parameter int N_ENTRIES       = 16,
  parameter int IDX_W           = 4,
  parameter int CH_W            = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FADE_FRAMES     = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  palette_ctrl_if.slave    wr,
  input  logic             swap_req,
  output logic             swap_pending,
  input  logic             frame_start,
  input  logic             fade_start,
  input  logic             fade_dir,
  output logic             fade_busy,
  input  logic             pix_valid,
  input  logic [IDX_W-1:0] pix_index,
  output logic             pix_out_valid,
  output logic [CH_W-1:0]  pix_red,
  output logic [CH_W-1:0]  pix_green,
  output logic [CH_W-1:0]  pix_blue,
  output logic             pix_transparent
);

  logic [3*CH_W-1:0] shadow_reg [N_ENTRIES];
  logic [3*CH_W-1:0] active_reg [N_ENTRIES];
  logic              swap_pending_reg;
  logic              wr_fire;
  logic              publish;
  logic [3:0]        level;

  logic              s1_valid_reg;
  logic [3*CH_W-1:0] s1_color_reg;
  logic              s1_transp_reg;

  assign wr.wr_ready   = !swap_pending_reg;
  assign wr_fire       = wr.wr_valid && !swap_pending_reg;
  assign publish       = frame_start && swap_pending_reg;
  assign swap_pending  = swap_pending_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      swap_pending_reg <= 1'b0;
    end else if (publish) begin
      swap_pending_reg <= 1'b0;
    end else if (swap_req) begin
      swap_pending_reg <= 1'b1;
    end
  end

  // Writes are blocked while a publish is pending, so a write and a copy
  // never land on the same edge.
  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        shadow_reg[gi] <= DEFAULT_PALETTE[gi];
      end else if (wr_fire && (wr.wr_index == IDX_W'(gi))) begin
        shadow_reg[gi] <= wr.wr_color;
      end
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        active_reg[gi] <= DEFAULT_PALETTE[gi];
      end else if (publish) begin
        active_reg[gi] <= shadow_reg[gi];
      end
    end
  end

  palette_fader #(
    .FADE_FRAMES (FADE_FRAMES)
  ) u_fader (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .fade_start  (fade_start),
    .fade_dir    (fade_dir),
    .level       (level),
    .fade_busy   (fade_busy)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_reg    <= 1'b0;
      s1_color_reg    <= '0;
      s1_transp_reg   <= 1'b0;
      pix_out_valid   <= 1'b0;
      pix_red         <= '0;
      pix_green       <= '0;
      pix_blue        <= '0;
      pix_transparent <= 1'b0;
    end else begin
      s1_valid_reg    <= pix_valid;
      s1_color_reg    <= active_reg[pix_index];
      s1_transp_reg   <= (pix_index == IDX_W'(TRANSPARENT_IDX));
      pix_out_valid   <= s1_valid_reg;
      pix_red         <= scale_channel(s1_color_reg[3*CH_W-1 -: CH_W], level);
      pix_green       <= scale_channel(s1_color_reg[2*CH_W-1 -: CH_W], level);
      pix_blue        <= scale_channel(s1_color_reg[CH_W-1   -: CH_W], level);
      pix_transparent <= s1_transp_reg;
    end
  end

endmodule

// File: tb/tb_palette_ctrl.sv
// Directed bench for palette_ctrl: lookups, shadow writes, frame-synchronous
// publish, fade sequencing and mid-operation reset.
module tb_palette_ctrl;
  import palette_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       swap_req, swap_pending, frame_start;
  logic       fade_start, fade_dir, fade_busy;
  logic       pix_valid, pix_out_valid, pix_transparent;
  logic [3:0] pix_index, pix_red, pix_green, pix_blue;

  int checks = 0;
  int passed = 0;

  palette_ctrl_if #(.IDX_W(4), .CH_W(4)) wr_if ();

  palette_ctrl #(
    .N_ENTRIES(16), .IDX_W(4), .CH_W(4), .TRANSPARENT_IDX(0), .FADE_FRAMES(1)
  ) u_dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .wr              (wr_if.slave),
    .swap_req        (swap_req),
    .swap_pending    (swap_pending),
    .frame_start     (frame_start),
    .fade_start      (fade_start),
    .fade_dir        (fade_dir),
    .fade_busy       (fade_busy),
    .pix_valid       (pix_valid),
    .pix_index       (pix_index),
    .pix_out_valid   (pix_out_valid),
    .pix_red         (pix_red),
    .pix_green       (pix_green),
    .pix_blue        (pix_blue),
    .pix_transparent (pix_transparent)
  );

  always #5 Clk = ~Clk;

  // Issue one lookup and return {valid, R, G, B, transparent} two cycles later.
  task automatic lookup(input logic [3:0] idx, output logic [13:0] res);
    @(negedge Clk);
    pix_valid = 1'b1;
    pix_index = idx;
    @(negedge Clk);
    pix_valid = 1'b0;
    @(negedge Clk);
    res = {pix_out_valid, pix_red, pix_green, pix_blue, pix_transparent};
  endtask

  task automatic pulse_frame(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      frame_start = 1'b1;
      @(negedge Clk);
      frame_start = 1'b0;
    end
  endtask

  task automatic pulse_swap();
    @(negedge Clk);
    swap_req = 1'b1;
    @(negedge Clk);
    swap_req = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic [11:0] col);
    @(negedge Clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_index = idx;
    wr_if.wr_color = col;
    @(negedge Clk);
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] r;
    checks++;
    if ({swap_pending, wr_if.wr_ready, fade_busy} !== 3'b010)
      $display("FAIL reset_flags: got pend/ready/busy=%b want 010", {swap_pending, wr_if.wr_ready, fade_busy});
    else passed++;
    checks++;
    if ({pix_out_valid, pix_red, pix_green, pix_blue, pix_transparent} !== 14'd0)
      $display("FAIL reset_pix: got %h want 0", {pix_out_valid, pix_red, pix_green, pix_blue, pix_transparent});
    else passed++;
    lookup(4'd1, r);
    checks++;
    if (r !== {1'b1, 12'h121, 1'b0}) $display("FAIL lookup_idx1: got %h want %h", r, {1'b1, 12'h121, 1'b0});
    else passed++;
    lookup(4'd0, r);
    checks++;
    if (r !== {1'b1, 12'hFFF, 1'b1}) $display("FAIL lookup_idx0: got %h want %h", r, {1'b1, 12'hFFF, 1'b1});
    else passed++;
    $display("test_reset done: %0d/%0d", passed, checks);
  endtask

  task automatic test_write_swap();
    logic [13:0] r;
    write_entry(4'd3, 12'hF00);
    lookup(4'd3, r);
    checks++;
    if (r !== {1'b1, 12'h454, 1'b0}) $display("FAIL shadow_not_visible: got %h want %h", r, {1'b1, 12'h454, 1'b0});
    else passed++;
    pulse_swap();
    checks++;
    if (swap_pending !== 1'b1) $display("FAIL swap_pending_set: got %b want 1", swap_pending);
    else passed++;
    pulse_frame(1);
    checks++;
    if (swap_pending !== 1'b0) $display("FAIL swap_pending_clear: got %b want 0", swap_pending);
    else passed++;
    lookup(4'd3, r);
    checks++;
    if (r !== {1'b1, 12'hF00, 1'b0}) $display("FAIL published_idx3: got %h want %h", r, {1'b1, 12'hF00, 1'b0});
    else passed++;
    $display("test_write_swap done: %0d/%0d", passed, checks);
  endtask

  task automatic test_write_blocked();
    logic [13:0] r;
    pulse_swap();
    @(negedge Clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_index = 4'd5;
    wr_if.wr_color = 12'h0F0;
    checks++;
    if (wr_if.wr_ready !== 1'b0) $display("FAIL ready_low_pending: got %b want 0", wr_if.wr_ready);
    else passed++;
    @(negedge Clk);
    @(negedge Clk);
    wr_if.wr_valid = 1'b0;
    pulse_frame(1);
    checks++;
    if (wr_if.wr_ready !== 1'b1) $display("FAIL ready_after_frame: got %b want 1", wr_if.wr_ready);
    else passed++;
    lookup(4'd5, r);
    checks++;
    if (r !== {1'b1, 12'h111, 1'b0}) $display("FAIL blocked_write_dropped: got %h want %h", r, {1'b1, 12'h111, 1'b0});
    else passed++;
    $display("test_write_blocked done: %0d/%0d", passed, checks);
  endtask

  task automatic test_simultaneous();
    logic [13:0] r;
    write_entry(4'd7, 12'h00F);
    @(negedge Clk);
    swap_req    = 1'b1;
    frame_start = 1'b1;
    @(negedge Clk);
    swap_req    = 1'b0;
    frame_start = 1'b0;
    checks++;
    if (swap_pending !== 1'b1) $display("FAIL swap_and_frame_pending: got %b want 1", swap_pending);
    else passed++;
    lookup(4'd7, r);
    checks++;
    if (r !== {1'b1, 12'h343, 1'b0}) $display("FAIL no_early_publish: got %h want %h", r, {1'b1, 12'h343, 1'b0});
    else passed++;
    pulse_frame(1);
    lookup(4'd7, r);
    checks++;
    if (r !== {1'b1, 12'h00F, 1'b0}) $display("FAIL second_frame_publish: got %h want %h", r, {1'b1, 12'h00F, 1'b0});
    else passed++;
    // Write accepted in the same cycle as swap_req joins the publish.
    @(negedge Clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_index = 4'd9;
    wr_if.wr_color = 12'h5A3;
    swap_req       = 1'b1;
    @(negedge Clk);
    wr_if.wr_valid = 1'b0;
    swap_req       = 1'b0;
    pulse_frame(1);
    lookup(4'd9, r);
    checks++;
    if (r !== {1'b1, 12'h5A3, 1'b0}) $display("FAIL write_with_swap: got %h want %h", r, {1'b1, 12'h5A3, 1'b0});
    else passed++;
    $display("test_simultaneous done: %0d/%0d", passed, checks);
  endtask

  task automatic test_copy_cycle();
    logic [13:0] r_old, r_new;
    write_entry(4'd2, 12'h123);
    pulse_swap();
    @(negedge Clk);
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_index   = 4'd2;
    @(negedge Clk);
    frame_start = 1'b0;
    @(negedge Clk);
    pix_valid = 1'b0;
    r_old = {pix_out_valid, pix_red, pix_green, pix_blue, pix_transparent};
    @(negedge Clk);
    r_new = {pix_out_valid, pix_red, pix_green, pix_blue, pix_transparent};
    checks++;
    if (r_old !== {1'b1, 12'h999, 1'b0}) $display("FAIL copy_cycle_old: got %h want %h", r_old, {1'b1, 12'h999, 1'b0});
    else passed++;
    checks++;
    if (r_new !== {1'b1, 12'h123, 1'b0}) $display("FAIL after_copy_new: got %h want %h", r_new, {1'b1, 12'h123, 1'b0});
    else passed++;
    $display("test_copy_cycle done: %0d/%0d", passed, checks);
  endtask

  task automatic test_fade();
    logic [13:0] r;
    @(negedge Clk);
    fade_start = 1'b1;
    fade_dir   = 1'b0;
    @(negedge Clk);
    fade_start = 1'b0;
    checks++;
    if (fade_busy !== 1'b1) $display("FAIL fade_out_busy: got %b want 1", fade_busy);
    else passed++;
    pulse_frame(8);
    lookup(4'd0, r);
    checks++;
    if (r !== {1'b1, 12'h777, 1'b1}) $display("FAIL fade_level7: got %h want %h", r, {1'b1, 12'h777, 1'b1});
    else passed++;
    pulse_frame(7);
    lookup(4'd0, r);
    checks++;
    if ({r, fade_busy} !== {1'b1, 12'h000, 1'b1, 1'b0})
      $display("FAIL fade_out_black: got %h busy %b want %h busy 0", r, fade_busy, {1'b1, 12'h000, 1'b1});
    else passed++;
    // Fade out again at level 0: one busy step boundary, no level change.
    @(negedge Clk);
    fade_start = 1'b1;
    @(negedge Clk);
    fade_start = 1'b0;
    checks++;
    if (fade_busy !== 1'b1) $display("FAIL endpoint_busy: got %b want 1", fade_busy);
    else passed++;
    pulse_frame(1);
    lookup(4'd0, r);
    checks++;
    if ({r, fade_busy} !== {1'b1, 12'h000, 1'b1, 1'b0})
      $display("FAIL endpoint_exit: got %h busy %b want %h busy 0", r, fade_busy, {1'b1, 12'h000, 1'b1});
    else passed++;
    @(negedge Clk);
    fade_start = 1'b1;
    fade_dir   = 1'b1;
    @(negedge Clk);
    fade_start = 1'b0;
    pulse_frame(14);
    lookup(4'd0, r);
    checks++;
    if ({r, fade_busy} !== {1'b1, 12'hEEE, 1'b1, 1'b1})
      $display("FAIL fade_in_level14: got %h busy %b want %h busy 1", r, fade_busy, {1'b1, 12'hEEE, 1'b1});
    else passed++;
    pulse_frame(1);
    lookup(4'd0, r);
    checks++;
    if ({r, fade_busy} !== {1'b1, 12'hFFF, 1'b1, 1'b0})
      $display("FAIL fade_in_done: got %h busy %b want %h busy 0", r, fade_busy, {1'b1, 12'hFFF, 1'b1});
    else passed++;
    $display("test_fade done: %0d/%0d", passed, checks);
  endtask

  task automatic test_reset_mid_op();
    logic [13:0] r;
    @(negedge Clk);
    fade_start = 1'b1;
    fade_dir   = 1'b0;
    @(negedge Clk);
    fade_start = 1'b0;
    pulse_frame(3);
    write_entry(4'd1, 12'hABC);
    pulse_swap();
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++;
    if ({swap_pending, fade_busy, wr_if.wr_ready} !== 3'b001)
      $display("FAIL async_reset_flags: got pend/busy/ready=%b want 001", {swap_pending, fade_busy, wr_if.wr_ready});
    else passed++;
    @(negedge Clk);
    Reset = 1'b0;
    lookup(4'd0, r);
    checks++;
    if (r !== {1'b1, 12'hFFF, 1'b1}) $display("FAIL reset_level15: got %h want %h", r, {1'b1, 12'hFFF, 1'b1});
    else passed++;
    lookup(4'd3, r);
    checks++;
    if (r !== {1'b1, 12'h454, 1'b0}) $display("FAIL reset_active_bank: got %h want %h", r, {1'b1, 12'h454, 1'b0});
    else passed++;
    pulse_swap();
    pulse_frame(1);
    lookup(4'd1, r);
    checks++;
    if (r !== {1'b1, 12'h121, 1'b0}) $display("FAIL reset_shadow_bank: got %h want %h", r, {1'b1, 12'h121, 1'b0});
    else passed++;
    $display("test_reset_mid_op done: %0d/%0d", passed, checks);
  endtask

  initial begin
    Reset          = 1'b1;
    swap_req       = 1'b0;
    frame_start    = 1'b0;
    fade_start     = 1'b0;
    fade_dir       = 1'b0;
    pix_valid      = 1'b0;
    pix_index      = 4'd0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_index = 4'd0;
    wr_if.wr_color = 12'h000;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    test_reset();
    test_write_swap();
    test_write_blocked();
    test_simultaneous();
    test_copy_cycle();
    test_fade();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
